// File: rtl/rssb_pkg.sv
// Shared types and default constants for the RSSB one-instruction core.
package rssb_pkg;

    localparam int         DEF_WIDTH     = 8;
    localparam logic [7:0] DEF_RESET_PC  = 8'h80;
    localparam logic [7:0] DEF_HALT_ADDR = 8'hFF;
    localparam int         DEF_CNT_W     = 16;

    // Sequencer states: an instruction takes one FETCH and one EXEC cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/rssb_alu.sv
// Reverse-subtract datapath: diff = a - b with the borrow out of the MSB.
module rssb_alu
    import rssb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] full_diff;

    // One extra bit so the borrow falls out of the subtraction directly.
    assign full_diff = {1'b0, a} - {1'b0, b};
    assign diff      = full_diff[WIDTH-1:0];
    assign borrow    = full_diff[WIDTH];

endmodule

// File: rtl/rssb_ctrl.sv
// Instruction sequencer for the RSSB core: fetch operand address at pc,
// then acc <= mem[a] - acc, mem[a] <= result, pc advances by 1 or 2.
module rssb_ctrl
    import rssb_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEF_RESET_PC),
    parameter logic [WIDTH-1:0] HALT_ADDR = WIDTH'(DEF_HALT_ADDR),
    parameter int               CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_write,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             halted,
    output logic             rom_wr_err,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] alu_diff;
    logic             alu_borrow;
    logic             in_exec;
    logic             target_is_rom;

    // Datapath: memory word at the operand address minus the accumulator.
    rssb_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (mem_rdata),
        .b      (acc_q),
        .diff   (alu_diff),
        .borrow (alu_borrow)
    );

    assign in_exec       = (state_q == EXEC);
    assign target_is_rom = ir_q[WIDTH-1];

    // Next-state logic for the sequencer, pc, acc, counter and error flag.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE, HALT: begin
                if (start && !stop) begin
                    pc_d    = RESET_PC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    ir_d = mem_rdata;
                    // An operand equal to HALT_ADDR stops the core; pc stays on it.
                    if (mem_rdata == HALT_ADDR) begin
                        state_d = HALT;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (stop) begin
                    // Aborted instruction: nothing retires, pc/acc hold.
                    state_d = IDLE;
                end else begin
                    acc_d = alu_diff;
                    pc_d  = pc_q + WIDTH'(1) + WIDTH'(alu_borrow);
                    if (target_is_rom) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered address: the operand during EXEC, otherwise the pc.
        addr_d = (state_d == EXEC) ? ir_d : pc_d;
    end

    // State register; reset takes priority over start and stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            acc_q   <= '0;
            ir_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Write data comes straight off the ALU so read and write share one EXEC cycle.
    assign mem_wdata   = in_exec ? alu_diff : '0;
    // Writes only into the RAM half; a stop in the same cycle cancels the write.
    assign mem_write   = in_exec && !target_is_rom && !stop;
    assign mem_addr    = addr_q;
    assign pc          = pc_q;
    assign acc         = acc_q;
    assign busy        = (state_q == FETCH) || (state_q == EXEC);
    assign halted      = (state_q == HALT);
    assign rom_wr_err  = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_rssb_ctrl.sv
// Self-checking bench for rssb_ctrl: directed table, hand-written corner
// sequences and random programs checked against an instruction-level model.
`timescale 1ns/1ps
module tb_rssb_ctrl;

    localparam int W  = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, sel_b;
    logic          start_a, stop_a, start_b, stop_b;
    logic [W-1:0]  rdata;
    logic [W-1:0]  addr_a, wdata_a, pc_a, acc_a;
    logic [W-1:0]  addr_b, wdata_b, pc_b, acc_b;
    logic          write_a, busy_a, halted_a, err_a;
    logic          write_b, busy_b, halted_b, err_b;
    logic [CW-1:0] cnt_a, cnt_b;

    // Main instance with the default start address.
    rssb_ctrl #(.WIDTH(W), .RESET_PC(8'h80), .HALT_ADDR(8'hFF), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .mem_rdata(rdata),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_write(write_a),
        .pc(pc_a), .acc(acc_a), .busy(busy_a), .halted(halted_a),
        .rom_wr_err(err_a), .instr_count(cnt_a));

    // Second instance starting near the top of memory for pc wrap-around.
    rssb_ctrl #(.WIDTH(W), .RESET_PC(8'hFE), .HALT_ADDR(8'hFF), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .mem_rdata(rdata),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_write(write_b),
        .pc(pc_b), .acc(acc_b), .busy(busy_b), .halted(halted_b),
        .rom_wr_err(err_b), .instr_count(cnt_b));

    // Shared memory; sel_b chooses which instance owns the port.
    logic [W-1:0] mem [256];
    logic         ld_en;
    logic [7:0]   ld_addr, ld_data;
    logic [W-1:0] bus_addr, bus_wdata;
    logic         bus_write;
    assign bus_addr  = sel_b ? addr_b  : addr_a;
    assign bus_wdata = sel_b ? wdata_b : wdata_a;
    assign bus_write = sel_b ? write_b : write_a;
    assign rdata     = mem[bus_addr];

    always @(posedge clk) begin
        if (ld_en)          mem[ld_addr]  <= ld_data;
        else if (bus_write) mem[bus_addr] <= bus_wdata;
    end

    int wr_cnt_a = 0;
    always @(negedge clk) if (write_a) wr_cnt_a <= wr_cnt_a + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [7:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_halt_a(output int cyc);
        cyc = 0;
        while (!halted_a && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic load_basic();
        ld(8'h10, 8'h05); ld(8'h11, 8'h03);
        ld(8'h80, 8'h10); ld(8'h81, 8'h11); ld(8'h82, 8'h12); ld(8'h83, 8'hFF);
    endtask

    typedef struct {
        logic [7:0] x;      // value the first instruction loads into acc
        logic [7:0] op;     // operand address of the second instruction
        logic [7:0] v;      // memory word at op
        logic [7:0] e_acc;
        logic [7:0] e_pc;
        logic       e_err;
    } vec_t;
    vec_t tbl [7];

    logic [7:0] img [256];
    logic [7:0] mm  [256];

    initial begin : main
        int cyc, w0, nbad, n;
        logic [7:0] mpc, macc, op, v, res, exp_mem;
        logic       merr, mhalt, bor;

        rst = 1'b1; sel_b = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;

        tbl[0] = '{8'h05, 8'h11, 8'h03, 8'hFE, 8'h83, 1'b0};
        tbl[1] = '{8'h03, 8'h11, 8'h05, 8'h02, 8'h82, 1'b0};
        tbl[2] = '{8'h07, 8'h11, 8'h07, 8'h00, 8'h82, 1'b0};
        tbl[3] = '{8'h00, 8'h11, 8'h00, 8'h00, 8'h82, 1'b0};
        tbl[4] = '{8'hFF, 8'h11, 8'h00, 8'h01, 8'h83, 1'b0};
        tbl[5] = '{8'h01, 8'hA0, 8'h00, 8'hFF, 8'h83, 1'b1};
        tbl[6] = '{8'h80, 8'h11, 8'h7F, 8'hFF, 8'h83, 1'b0};

        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_pc", pc_a, 8'h80);
        chk("rst_acc", acc_a, 8'h00);
        chk("rst_addr", addr_a, 8'h00);
        chk("rst_wdata", wdata_a, 8'h00);
        chk("rst_write", write_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_halted", halted_a, 1'b0);
        chk("rst_err", err_a, 1'b0);
        chk("rst_cnt", cnt_a, 16'h0);

        for (int i = 0; i < 256; i++) ld(8'(i), 8'h00);
        chk("idle_addr_pc", addr_a, 8'h80);

        // Basic program with cycle-exact checks
        load_basic();
        pulse_start_a();
        chk("b_fetch_busy", busy_a, 1'b1);
        chk("b_fetch_addr", addr_a, 8'h80);
        tick();
        chk("b_exec_addr", addr_a, 8'h10);
        chk("b_exec_write", write_a, 1'b1);
        chk("b_exec_wdata", wdata_a, 8'h05);
        tick();
        chk("b_i1_acc", acc_a, 8'h05);
        chk("b_i1_pc", pc_a, 8'h81);
        chk("b_i1_ram10", mem[8'h10], 8'h05);
        tick(); tick();
        chk("b_i2_acc", acc_a, 8'hFE);
        chk("b_i2_pc", pc_a, 8'h83);
        chk("b_i2_ram11", mem[8'h11], 8'hFE);
        tick();
        chk("b_halted", halted_a, 1'b1);
        chk("b_busy", busy_a, 1'b0);
        chk("b_cnt", cnt_a, 16'd2);
        chk("b_halt_pc", pc_a, 8'h83);

        // Table of two-instruction programs
        for (int k = 0; k < 7; k++) begin
            ld(8'h80, 8'h10); ld(8'h10, tbl[k].x); ld(8'h81, tbl[k].op);
            ld(tbl[k].op, tbl[k].v); ld(8'h82, 8'hFF); ld(8'h83, 8'hFF);
            pulse_start_a();
            wait_halt_a(cyc);
            exp_mem = tbl[k].op[7] ? tbl[k].v : tbl[k].e_acc;
            chk($sformatf("t%0d_cycles", k), cyc, 5);
            chk($sformatf("t%0d_acc", k), acc_a, tbl[k].e_acc);
            chk($sformatf("t%0d_pc", k), pc_a, tbl[k].e_pc);
            chk($sformatf("t%0d_err", k), err_a, tbl[k].e_err);
            chk($sformatf("t%0d_mem", k), mem[tbl[k].op], exp_mem);
            chk($sformatf("t%0d_cnt", k), cnt_a, 16'd2);
        end

        // ROM target: no write strobe, sticky error, acc still updated
        ld(8'h80, 8'h90); ld(8'h90, 8'h07); ld(8'h81, 8'hFF);
        w0 = wr_cnt_a;
        pulse_start_a();
        wait_halt_a(cyc);
        chk("rom_no_write", wr_cnt_a, w0);
        chk("rom_err", err_a, 1'b1);
        chk("rom_acc", acc_a, 8'h07);
        chk("rom_pc", pc_a, 8'h81);
        chk("rom_mem", mem[8'h90], 8'h07);
        chk("rom_halted", halted_a, 1'b1);

        // Stop mid-EXEC (start from HALT also clears the error flag)
        load_basic();
        w0 = wr_cnt_a;
        pulse_start_a();
        chk("restart_err_clr", err_a, 1'b0);
        tick();
        stop_a = 1'b1;
        #1;
        chk("stop_exec_write", write_a, 1'b0);
        tick();
        stop_a = 1'b0;
        chk("stop_exec_busy", busy_a, 1'b0);
        chk("stop_exec_halted", halted_a, 1'b0);
        chk("stop_exec_cnt", cnt_a, 16'd0);
        chk("stop_exec_ram", mem[8'h10], 8'h05);
        chk("stop_exec_nowr", wr_cnt_a, w0);
        chk("stop_exec_pc", pc_a, 8'h80);
        chk("stop_exec_acc", acc_a, 8'h00);

        // Stop in FETCH after one retired instruction: pc/acc hold
        pulse_start_a();
        tick(); tick();
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        chk("stop_fetch_busy", busy_a, 1'b0);
        chk("stop_fetch_pc", pc_a, 8'h81);
        chk("stop_fetch_acc", acc_a, 8'h05);
        chk("stop_fetch_cnt", cnt_a, 16'd1);

        // Reset during EXEC, then a clean re-run
        load_basic();
        pulse_start_a();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_pc", pc_a, 8'h80);
        chk("mr_acc", acc_a, 8'h00);
        chk("mr_addr", addr_a, 8'h00);
        chk("mr_wdata", wdata_a, 8'h00);
        chk("mr_write", write_a, 1'b0);
        chk("mr_busy", busy_a, 1'b0);
        chk("mr_halted", halted_a, 1'b0);
        chk("mr_cnt", cnt_a, 16'd0);
        load_basic();
        pulse_start_a();
        wait_halt_a(cyc);
        chk("rr_cycles", cyc, 5);
        chk("rr_acc", acc_a, 8'hFE);
        chk("rr_pc", pc_a, 8'h83);
        chk("rr_ram10", mem[8'h10], 8'h05);
        chk("rr_ram11", mem[8'h11], 8'hFE);
        chk("rr_cnt", cnt_a, 16'd2);

        // Start held while busy is ignored; start+stop together stops
        load_basic();
        start_a = 1'b1;
        tick(); tick(); tick();
        chk("sb_pc", pc_a, 8'h81);
        chk("sb_acc", acc_a, 8'h05);
        chk("sb_busy", busy_a, 1'b1);
        stop_a = 1'b1;
        tick();
        chk("ss_busy", busy_a, 1'b0);
        chk("ss_halted", halted_a, 1'b0);
        tick();
        chk("ss_stays_idle", busy_a, 1'b0);
        start_a = 1'b0; stop_a = 1'b0;

        // PC wrap, no borrow: FE -> FF -> 00
        sel_b = 1'b1;
        ld(8'hFE, 8'h21); ld(8'h21, 8'h00); ld(8'hFF, 8'h20); ld(8'h20, 8'h00);
        ld(8'h00, 8'hFF); ld(8'h01, 8'hFF);
        start_b = 1'b1; tick(); start_b = 1'b0;
        tick(); tick();
        chk("wrap0_pc_ff", pc_b, 8'hFF);
        tick(); tick();
        chk("wrap0_pc", pc_b, 8'h00);
        chk("wrap0_acc", acc_b, 8'h00);
        tick();
        chk("wrap0_halted", halted_b, 1'b1);

        // PC wrap with borrow: FF + 2 -> 01
        ld(8'h21, 8'h01); ld(8'h20, 8'h00);
        start_b = 1'b1; tick(); start_b = 1'b0;
        tick(); tick();
        chk("wrap1_acc1", acc_b, 8'h01);
        tick(); tick();
        chk("wrap1_pc", pc_b, 8'h01);
        chk("wrap1_acc", acc_b, 8'hFF);
        chk("wrap1_ram20", mem[8'h20], 8'hFF);
        tick();
        chk("wrap1_halted", halted_b, 1'b1);
        chk("wrap1_cnt", cnt_b, 16'd2);
        sel_b = 1'b0;

        // Random programs against an instruction-level model
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 256; i++) begin
                if (i >= 128 && $urandom_range(0, 5) == 0) img[i] = 8'hFF;
                else img[i] = 8'($urandom);
                mm[i] = img[i];
            end
            for (int i = 0; i < 256; i++) ld(8'(i), img[i]);

            mpc = 8'h80; macc = 8'h00; merr = 1'b0; mhalt = 1'b0; n = 0;
            while (!mhalt && n < 30) begin
                op = mm[mpc];
                if (op == 8'hFF) begin
                    mhalt = 1'b1;
                end else begin
                    v    = mm[op];
                    res  = 8'(int'(v) - int'(macc));
                    bor  = (v < macc);
                    if (op < 8'h80) mm[op] = res;
                    else merr = 1'b1;
                    macc = res;
                    mpc  = 8'(int'(mpc) + 1 + (bor ? 1 : 0));
                    n++;
                end
            end

            pulse_start_a();
            if (mhalt) begin
                repeat (2 * n + 1) tick();
            end else begin
                repeat (60) tick();
                stop_a = 1'b1;
                tick();
                stop_a = 1'b0;
            end
            nbad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) nbad++;
            chk($sformatf("r%0d_halted", it), halted_a, mhalt);
            chk($sformatf("r%0d_busy", it), busy_a, 1'b0);
            chk($sformatf("r%0d_acc", it), acc_a, macc);
            chk($sformatf("r%0d_pc", it), pc_a, mpc);
            chk($sformatf("r%0d_cnt", it), cnt_a, n);
            chk($sformatf("r%0d_err", it), err_a, merr);
            chk($sformatf("r%0d_mem_bad_words", it), nbad, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
